inst_fetch_axi: RTL

- AXI3 read-channel fetch unit directly upstream of the two IF stages.
- Accepts one fetch request per PC pair and issues a single AR burst (1 or 2 beats).
- Assembles the returned words into an instruction pair with PCs and presents it to IF_1/IF_2 over a valid/accept handshake.
- Replaces the ad-hoc arvalid/flag logic in the core top; one outstanding transaction, flush-safe.

---
 rtl/inst_fetch_axi.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/inst_fetch_axi.sv
// AXI3 read-channel instruction-pair fetch unit feeding IF_1/IF_2; one outstanding burst, flush-safe.
// Optional INST_FETCH_BYPASS_EN presents the pair combinationally on the rlast beat.
module inst_fetch_axi #(
    parameter logic [3:0]  ARID_VAL = 4'd0,
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        fetch_ready,
    input  logic        flush,
    output logic        arvalid,
    output logic [31:0] araddr,
    output logic [3:0]  arid,
    output logic [3:0]  arlen,
    output logic [2:0]  arsize,
    output logic [1:0]  arburst,
    output logic [1:0]  arlock,
    output logic [3:0]  arcache,
    output logic [2:0]  arprot,
    input  logic        arready,
    input  logic        rvalid,
    input  logic [31:0] rdata,
    input  logic [3:0]  rid,
    input  logic [1:0]  rresp,
    input  logic        rlast,
    output logic        rready,
    output logic        inst_valid,
    output logic        inst_2_valid,
    output logic [31:0] inst_1,
    output logic [31:0] inst_2,
    output logic [31:0] pc_1,
    output logic [31:0] pc_2,
    input  logic        inst_accept,
    output logic        inst_err
);

`ifdef INST_FETCH_BYPASS_EN
    localparam bit BypassEn = 1'b1;
`else
    localparam bit BypassEn = 1'b0;
`endif

    typedef enum logic [2:0] {StIdle, StAddr, StData, StDrain, StHold} state_e;

    state_e      state_q, state_d;
    logic [31:0] araddr_q, araddr_d;
    logic [3:0]  arlen_q, arlen_d;
    logic [31:0] pc_1_q, pc_1_d;
    logic [31:0] inst_1_q, inst_1_d;
    logic [31:0] inst_2_q, inst_2_d;
    logic        inst_2_valid_q, inst_2_valid_d;
    logic        inst_err_q, inst_err_d;
    logic        beat_q, beat_d;
    logic        flush_pend_q, flush_pend_d;
    logic        beat_ok;
    logic        byp_fire;

    assign arid    = ARID_VAL;
    assign arsize  = 3'b010;
    assign arburst = 2'b01;
    assign arlock  = 2'b00;
    assign arcache = 4'b0000;
    assign arprot  = 3'b000;

    // Beats carrying a foreign id are consumed but otherwise invisible.
    assign beat_ok = rvalid && (rid == ARID_VAL);

    always_comb begin
        state_d        = state_q;
        araddr_d       = araddr_q;
        arlen_d        = arlen_q;
        pc_1_d         = pc_1_q;
        inst_1_d       = inst_1_q;
        inst_2_d       = inst_2_q;
        inst_2_valid_d = inst_2_valid_q;
        inst_err_d     = inst_err_q;
        beat_d         = beat_q;
        flush_pend_d   = flush_pend_q;
        byp_fire       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (fetch_req) begin
                    pc_1_d       = fetch_pc;
                    inst_1_d     = 32'd0;
                    inst_2_d     = 32'd0;
                    beat_d       = 1'b0;
                    flush_pend_d = 1'b0;
                    if (fetch_pc[1:0] != 2'b00) begin
                        inst_err_d     = 1'b1;
                        inst_2_valid_d = 1'b0;
                        state_d        = StHold;
                    end else begin
                        // A pair never crosses an 8-byte boundary: odd word fetches alone.
                        inst_err_d     = 1'b0;
                        araddr_d       = fetch_pc;
                        arlen_d        = fetch_pc[2] ? 4'd0 : 4'd1;
                        inst_2_valid_d = ~fetch_pc[2];
                        state_d        = StAddr;
                    end
                end
            end
            StAddr: begin
                // AR cannot be withdrawn once raised; remember the flush until the handshake.
                if (flush) begin
                    flush_pend_d = 1'b1;
                end
                if (arready) begin
                    state_d = (flush || flush_pend_q) ? StDrain : StData;
                end
            end
            StData: begin
                if (beat_ok) begin
                    if (!beat_q) begin
                        inst_1_d = rdata;
                    end else begin
                        inst_2_d = rdata;
                    end
                    beat_d = 1'b1;
                    if (rresp != 2'b00) begin
                        inst_err_d = 1'b1;
                    end
                    if (rlast && !beat_q && (arlen_q != 4'd0)) begin
                        inst_err_d     = 1'b1;
                        inst_2_valid_d = 1'b0;
                    end
                    if (rlast) begin
                        if (flush) begin
                            state_d = StIdle;
                        end else begin
                            state_d = StHold;
                            if (BypassEn) begin
                                byp_fire = 1'b1;
                                if (inst_accept) begin
                                    state_d = StIdle;
                                end
                            end
                        end
                    end else if (flush) begin
                        state_d = StDrain;
                    end
                end else if (flush) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (beat_ok && rlast) begin
                    state_d = StIdle;
                end
            end
            StHold: begin
                if (flush || inst_accept) begin
                    inst_err_d = 1'b0;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= StIdle;
            araddr_q       <= 32'd0;
            arlen_q        <= 4'd0;
            pc_1_q         <= RESET_PC;
            inst_1_q       <= 32'd0;
            inst_2_q       <= 32'd0;
            inst_2_valid_q <= 1'b0;
            inst_err_q     <= 1'b0;
            beat_q         <= 1'b0;
            flush_pend_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            araddr_q       <= araddr_d;
            arlen_q        <= arlen_d;
            pc_1_q         <= pc_1_d;
            inst_1_q       <= inst_1_d;
            inst_2_q       <= inst_2_d;
            inst_2_valid_q <= inst_2_valid_d;
            inst_err_q     <= inst_err_d;
            beat_q         <= beat_d;
            flush_pend_q   <= flush_pend_d;
        end
    end

    assign fetch_ready  = (state_q == StIdle);
    assign arvalid      = (state_q == StAddr);
    assign araddr       = araddr_q;
    assign arlen        = arlen_q;
    assign rready       = (state_q == StData) || (state_q == StDrain);
    assign inst_valid   = (state_q == StHold) || byp_fire;
    assign inst_1       = byp_fire ? inst_1_d : inst_1_q;
    assign inst_2       = byp_fire ? inst_2_d : inst_2_q;
    assign inst_2_valid = inst_valid && (byp_fire ? inst_2_valid_d : inst_2_valid_q);
    assign inst_err     = inst_valid && (byp_fire ? inst_err_d : inst_err_q);
    assign pc_1         = pc_1_q;
    assign pc_2         = pc_1_q + 32'd4;

endmodule
